// File: rtl/matrix_pkg.sv
// Shared types for the element-wise matrix engine: operation and FSM state encodings.
package matrix_pkg;

  typedef enum logic [1:0] {
    EW_ADD  = 2'd0,
    EW_SUB  = 2'd1,
    EW_RSUB = 2'd2,
    EW_ABSD = 2'd3
  } ew_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ew_state_e;

endpackage

// File: rtl/matrix_elementwise_ew_alu.sv
// ew_alu: one lane of element-wise arithmetic (ADD, SUB, RSUB, ABSD) on DW-bit operands.
// Result is DW+1 bits. With MATRIX_EW_SAT_EN defined the result saturates to the DW-bit
// range of the selected signedness before being extended.
module ew_alu
  import matrix_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  ew_op_e        op,
  input  logic          is_signed,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW:0]   res
);

`ifdef MATRIX_EW_SAT_EN
  // One guard bit beyond DW+1 so the true value can be compared against the DW-bit range.
  localparam int unsigned XW = DW + 2;
  localparam logic signed [XW-1:0] SMAX = {3'b000, {(DW-1){1'b1}}};
  localparam logic signed [XW-1:0] SMIN = {3'b111, {(DW-1){1'b0}}};
  localparam logic signed [XW-1:0] UMAX = {2'b00, {DW{1'b1}}};
`else
  localparam int unsigned XW = DW + 1;
`endif

  logic signed [XW-1:0] xa;
  logic signed [XW-1:0] xb;
  logic signed [XW-1:0] diff;
  logic signed [XW-1:0] full;

  // Extend operands, compute the selected operation, then optionally saturate.
  always_comb begin
    xa   = is_signed ? {{(XW-DW){a[DW-1]}}, a} : {{(XW-DW){1'b0}}, a};
    xb   = is_signed ? {{(XW-DW){b[DW-1]}}, b} : {{(XW-DW){1'b0}}, b};
    diff = xa - xb;
    case (op)
      EW_ADD:  full = xa + xb;
      EW_SUB:  full = diff;
      EW_RSUB: full = xb - xa;
      default: full = diff[XW-1] ? -diff : diff;
    endcase
`ifdef MATRIX_EW_SAT_EN
    res = full[DW:0];
    if (is_signed) begin
      if (full > SMAX)      res = SMAX[DW:0];
      else if (full < SMIN) res = SMIN[DW:0];
    end else begin
      if (full > UMAX)      res = UMAX[DW:0];
      else if (full[XW-1])  res = '0;
    end
`else
    res = full;
`endif
  end

endmodule

// File: rtl/matrix_elementwise.sv
// matrix_elementwise: snapshots two ROWS x COLS operand matrices on start and computes
// c = op(a, b) element-wise, LANES elements per cycle in row-major order.
// Optional saturation of results is enabled by defining MATRIX_EW_SAT_EN.
module matrix_elementwise
  import matrix_pkg::*;
#(
  parameter int unsigned ROWS  = 4,
  parameter int unsigned COLS  = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned LANES = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          start,
  input  logic [1:0]                    op,
  input  logic                          is_signed,
  input  logic [ROWS*COLS*DW-1:0]       a,
  input  logic [ROWS*COLS*DW-1:0]       b,
  output logic [ROWS*COLS*(DW+1)-1:0]   c,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned NE = ROWS * COLS;
  localparam int unsigned N  = NE / LANES;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned RW = DW + 1;

  if (NE % LANES != 0) begin : g_lanes_check
    $error("matrix_elementwise: ROWS*COLS must be a multiple of LANES");
  end

  ew_state_e             state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NE*DW-1:0]      a_q, a_d;
  logic [NE*DW-1:0]      b_q, b_d;
  ew_op_e                op_q, op_d;
  logic                  sgn_q, sgn_d;
  logic [NE*RW-1:0]      c_q, c_d;

  logic [LANES*DW-1:0]   beat_a;
  logic [LANES*DW-1:0]   beat_b;
  logic [LANES*RW-1:0]   beat_r;

  // Select the snapshot operands belonging to the current beat.
  always_comb begin
    beat_a = '0;
    beat_b = '0;
    for (int unsigned t = 0; t < N; t++) begin
      if (idx_q == IW'(t)) begin
        beat_a = a_q[t*LANES*DW +: LANES*DW];
        beat_b = b_q[t*LANES*DW +: LANES*DW];
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    ew_alu #(.DW(DW)) u_alu (
      .op        (op_q),
      .is_signed (sgn_q),
      .a         (beat_a[l*DW +: DW]),
      .b         (beat_b[l*DW +: DW]),
      .res       (beat_r[l*RW +: RW])
    );
  end

  // Next-state logic: accept/snapshot in IDLE, one beat per cycle in RUN, clr overrides all.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    sgn_d   = sgn_q;
    c_d     = c_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          idx_d   = '0;
          a_d     = a;
          b_d     = b;
          op_d    = ew_op_e'(op);
          sgn_d   = is_signed;
        end
      end
      ST_RUN: begin
        for (int unsigned t = 0; t < N; t++) begin
          if (idx_q == IW'(t)) c_d[t*LANES*RW +: LANES*RW] = beat_r;
        end
        if (idx_q == IW'(N - 1)) state_d = ST_DONE;
        else                     idx_d   = idx_q + 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // clr wins over a simultaneous start, so the snapshot is left untouched too.
    if (clr) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      sgn_d   = sgn_q;
      c_d     = '0;
    end
  end

  // State, index, snapshot and result registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= EW_ADD;
      sgn_q   <= 1'b0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      sgn_q   <= sgn_d;
      c_q     <= c_d;
    end
  end

  assign c    = c_q;
  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_matrix_elementwise.sv
// Self-checking bench for matrix_elementwise: directed corner cases plus randomized
// operations compared against an integer-arithmetic reference model.
module tb_matrix_elementwise;

  localparam int unsigned ROWS = 4;
  localparam int unsigned COLS = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned NE   = ROWS * COLS;
  localparam int unsigned RW   = DW + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clr;
  logic              start;
  logic              start4;
  logic [1:0]        op;
  logic              is_signed;
  logic [NE*DW-1:0]  a;
  logic [NE*DW-1:0]  b;
  logic [NE*RW-1:0]  c;
  logic [NE*RW-1:0]  c4;
  logic              busy, done, busy4, done4;

  int checks = 0;
  int errors = 0;
  logic [RW-1:0] model_c [NE];

  always #5 clk = ~clk;

  matrix_elementwise #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .LANES(1)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .start(start), .op(op), .is_signed(is_signed),
    .a(a), .b(b), .c(c), .busy(busy), .done(done)
  );

  matrix_elementwise #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .LANES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .start(start4), .op(op), .is_signed(is_signed),
    .a(a), .b(b), .c(c4), .busy(busy4), .done(done4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: true integer result, optional clamp, truncated to DW+1 bits.
  function automatic logic [RW-1:0] ref_elem(input logic [1:0] o, input logic s,
                                              input logic [DW-1:0] x, input logic [DW-1:0] y);
    int vx, vy, r;
    vx = s ? int'($signed(x)) : int'(x);
    vy = s ? int'($signed(y)) : int'(y);
    case (o)
      2'd0:    r = vx + vy;
      2'd1:    r = vx - vy;
      2'd2:    r = vy - vx;
      default: r = (vx > vy) ? vx - vy : vy - vx;
    endcase
`ifdef MATRIX_EW_SAT_EN
    if (s) begin
      if (r > (1 << (DW-1)) - 1) r = (1 << (DW-1)) - 1;
      if (r < -(1 << (DW-1)))    r = -(1 << (DW-1));
    end else begin
      if (r > (1 << DW) - 1) r = (1 << DW) - 1;
      if (r < 0)             r = 0;
    end
`endif
    return r[RW-1:0];
  endfunction

  function automatic logic [NE*DW-1:0] fill(input logic [DW-1:0] v);
    return {NE{v}};
  endfunction

  function automatic logic [NE*DW-1:0] rand_vec();
    logic [NE*DW-1:0] v;
    for (int i = 0; i < NE; i++) v[i*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NE; i++) model_c[i] = '0;
  endtask

  task automatic watch_no_done(input string tag, input int cycles);
    int dcount;
    dcount = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check(tag, dcount, 0);
  endtask

  // One full operation on the LANES=1 instance; optionally disturbs inputs mid-run.
  task automatic run_op(input string tag, input logic [1:0] o, input logic s,
                        input logic [NE*DW-1:0] av, input logic [NE*DW-1:0] bv,
                        input bit disturb);
    logic [RW-1:0] exp_new [NE];
    int n;
    int dcount;
    for (int i = 0; i < NE; i++) exp_new[i] = ref_elem(o, s, av[i*DW +: DW], bv[i*DW +: DW]);
    @(negedge clk);
    a = av; b = bv; op = o; is_signed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (disturb) begin
      a = ~av; b = rand_vec(); op = o + 2'd1; is_signed = ~s;
    end
    n = 0;
    while (!done && n < int'(NE) + 4) begin
      check({tag, "_busy_run"}, busy, 1);
      if (n == 3) begin
        check({tag, "_partial_written"}, c[2*RW +: RW], exp_new[2]);
        check({tag, "_partial_held"}, c[(NE-1)*RW +: RW], model_c[NE-1]);
      end
      start = (disturb && n == 5);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check({tag, "_done_latency"}, n, NE);
    check({tag, "_busy_in_done"}, busy, 1);
    for (int i = 0; i < NE; i++) check({tag, "_elem"}, c[i*RW +: RW], exp_new[i]);
    for (int i = 0; i < NE; i++) model_c[i] = exp_new[i];
    @(negedge clk);
    check({tag, "_done_pulse_end"}, done, 0);
    check({tag, "_busy_end"}, busy, 0);
    dcount = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    check({tag, "_idle_after"}, dcount, 0);
    check({tag, "_idle_stable"}, c[0 +: RW], model_c[0]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_n = 1'b0; clr = 1'b0; start = 1'b0; start4 = 1'b0;
    op = 2'd0; is_signed = 1'b0; a = '0; b = '0;
    model_clear();
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_c_nonzero", 32'(c != '0), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases.
    run_op("sub_basic", 2'd1, 1'b0, fill(8'd5), fill(8'd3), 1'b0);
    check("sub_basic_const", c[0 +: RW], 9'h002);
    run_op("sub_uflow", 2'd1, 1'b0, fill(8'd0), fill(8'd255), 1'b0);
    run_op("add_sovf", 2'd0, 1'b1, fill(8'd127), fill(8'd127), 1'b0);
    run_op("absd_s", 2'd3, 1'b1, fill(8'h80), fill(8'h7F), 1'b0);
    run_op("rsub_u", 2'd2, 1'b0, fill(8'd3), fill(8'd10), 1'b0);
    check("rsub_u_const", c[5*RW +: RW], 9'h007);

    // Inputs changed and start re-pulsed mid-run must not disturb the operation.
    run_op("snapshot", 2'd0, 1'b1, rand_vec(), rand_vec(), 1'b1);

    // LANES=4 instance: a=i, b=2i -> 3i, done four edges after accept.
    @(negedge clk);
    for (int i = 0; i < NE; i++) begin
      a[i*DW +: DW] = DW'(i);
      b[i*DW +: DW] = DW'(2*i);
    end
    op = 2'd0; is_signed = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    n = 0;
    while (!done4 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("lanes4_done_latency", n, 4);
    for (int i = 0; i < NE; i++) check("lanes4_elem", c4[i*RW +: RW], 32'(3*i));
    @(negedge clk);
    check("lanes4_done_end", done4, 0);
    check("lanes4_busy_end", busy4, 0);

    // clr at beat 7 aborts and zeroes the results.
    @(negedge clk);
    a = rand_vec(); b = rand_vec(); op = 2'd3; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 7; i++) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_busy", busy, 0);
    check("clr_done", done, 0);
    for (int i = 0; i < NE; i++) check("clr_elem_zero", c[i*RW +: RW], 0);
    model_clear();
    watch_no_done("clr_no_done", 20);

    // clr together with start in IDLE: start is suppressed.
    @(negedge clk);
    clr = 1'b1; start = 1'b1;
    @(negedge clk);
    clr = 1'b0; start = 1'b0;
    check("clr_start_busy", busy, 0);
    watch_no_done("clr_start_no_done", 20);
    run_op("after_clr", 2'd1, 1'b1, rand_vec(), rand_vec(), 1'b0);

    // Asynchronous reset at beat 7.
    @(negedge clk);
    a = rand_vec(); b = rand_vec(); op = 2'd0; is_signed = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 7; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    for (int i = 0; i < NE; i++) check("rst_elem_zero", c[i*RW +: RW], 0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    watch_no_done("rst_no_done", 20);
    run_op("after_rst", 2'd2, 1'b1, rand_vec(), rand_vec(), 1'b0);

    // Randomized operations.
    for (int k = 0; k < 12; k++) begin
      run_op("rand", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             rand_vec(), rand_vec(), bit'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_elementwise.md
MATRIX_ELEMENTWISE -- requirements
Module: matrix_elementwise

Interface
REQ-001 SHALL have parameter ROWS, 4, matrix rows (>=1).
REQ-002 SHALL have parameter COLS, 4, matrix columns (>=1).
REQ-003 SHALL have parameter DW, 8, operand element width in bits (>=2).
REQ-004 SHALL have parameter LANES, 1, elements computed per cycle; ROWS*COLS SHALL be a multiple of LANES (elaboration error otherwise).
REQ-005 SHALL have port clk  input  1  clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port clr  input  1  synchronous abort and clear.
REQ-008 SHALL have port start  input  1  request, sampled only in IDLE.
REQ-009 SHALL have port op  input  2  operation: 0 ADD a+b, 1 SUB a-b, 2 RSUB b-a, 3 ABSD |a-b|.
REQ-010 SHALL have port is_signed  input  1  operands two's complement when 1, unsigned when 0.
REQ-011 SHALL have port a  input  ROWS*COLS*DW  operand A; element (r,c) at bit offset (r*COLS+c)*DW.
REQ-012 SHALL have port b  input  ROWS*COLS*DW  operand B, same layout as a.
REQ-013 SHALL have port c  output  ROWS*COLS*(DW+1)  result, offset (r*COLS+c)*(DW+1).
REQ-014 SHALL have port busy  output  1  high in RUN and DONE.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE, with reset state IDLE.
REQ-017 IDLE->RUN SHALL occur on the edge where start=1 and clr=0; that edge SHALL snapshot a, b, op and is_signed into internal registers.
REQ-018 Changes on a, b, op and is_signed after the snapshot SHALL NOT affect the operation in progress.
REQ-019 start in RUN or DONE SHALL be ignored (not queued).
REQ-020 RUN SHALL process N=ROWS*COLS/LANES beats in row-major order; beat t SHALL write elements t*LANES..t*LANES+LANES-1 on edge k+1+t, where k is the accept edge.
REQ-021 After the final beat write (edge k+N) the FSM SHALL enter DONE; done SHALL be 1 for exactly that cycle; the next edge SHALL return to IDLE with done=0.
REQ-022 The index counter SHALL be $clog2(N) bits (min 1) and SHALL reset to 0 on every accept.
REQ-023 Each operand SHALL be extended to DW+1 bits (sign-extended if is_signed, else zero-extended) before the operation; ADD/SUB/RSUB results SHALL be exact in DW+1 bits.
REQ-024 ABSD SHALL produce the unsigned magnitude, 0..2^DW-1, zero-extended.
REQ-025 c elements not yet written in the current operation SHALL hold prior values; c SHALL be stable in IDLE.
REQ-026 clr=1 SHALL, on the next edge, force IDLE, zero all of c, deassert busy/done and suppress start; clr SHALL override a simultaneous start.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, c=0, busy=0, done=0, index=0 and snapshot registers=0, including mid-RUN; no done SHALL follow reset.

Configuration
REQ-028 With MATRIX_EW_SAT_EN defined, each result SHALL saturate to the DW-bit range: signed [-2^(DW-1), 2^(DW-1)-1], unsigned [0, 2^DW-1], then be extended to DW+1 bits. ABSD results SHALL clamp to 2^(DW-1)-1 when is_signed=1.
REQ-029 Without MATRIX_EW_SAT_EN, results SHALL be the exact DW+1-bit values of REQ-023/REQ-024; port widths SHALL be identical in both builds.

Structure
REQ-030 Shared package matrix_pkg SHALL hold the op enum (EW_ADD, EW_SUB, EW_RSUB, EW_ABSD) and the FSM state enum.
REQ-031 Per-lane arithmetic SHALL be a combinational sub-module ew_alu (op, is_signed, a, b -> DW+1 result, saturation under the macro), instantiated LANES times.

Verification
REQ-032 4x4, DW=8, LANES=1, SUB, unsigned, a=all 5, b=all 3, start -> every c=9'h002; busy for 17 cycles; done high exactly 16 edges after the accept edge.
REQ-033 SUB, unsigned, a=0, b=255 -> c=9'h101 without the macro, 9'h000 with it; signed ADD of 127+127 -> 9'h0FE without the macro, 9'h07F with it.
REQ-034 ABSD signed, a=-128 (8'h80), b=127 -> 9'h0FF without the macro, 9'h07F with it; RSUB unsigned, a=3, b=10 -> 9'h007.
REQ-035 Accept start, then change a and pulse start at beat 5 -> result reflects the original a; only one done pulse occurs.
REQ-036 LANES=4, ADD, a=i, b=2i per element i -> c[i]=3i; done 4 edges after accept.
REQ-037 Assert clr at beat 7 (and, separately, drop rst_n at beat 7) -> c all zero, busy=0, no done; a following start completes normally.
